// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words,
// writes them from BASE_ADDR upward and releases the core reset when the load completes.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    output logic             core_rst,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] word_cnt_r;
    logic [1:0]       byte_idx_r;
    logic [23:0]      word_buf_r;
    logic [CNT_W-1:0] word_cnt_nxt_s;

    // Byte address of word n, wrapping modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] n);
        logic [31:0] n32;
        n32 = 32'(n);
        return BASE_ADDR + (n32 << 2);
    endfunction

    assign word_cnt_nxt_s = word_cnt_r + CNT_W'(1);

    // Load FSM with registered outputs; all outputs are updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            count_r    <= '0;
            word_cnt_r <= '0;
            byte_idx_r <= 2'd0;
            word_buf_r <= 24'd0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wd     <= 32'd0;
            core_rst   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    mem_we <= 1'b0;
                    if (start) begin
                        count_r    <= word_count;
                        word_cnt_r <= '0;
                        byte_idx_r <= 2'd0;
                        if (word_count != '0) begin
                            state_r    <= LOAD;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                            done       <= 1'b0;
                            core_rst   <= 1'b0;
                        end else begin
                            state_r    <= DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            core_rst   <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                LOAD: begin
                    mem_we <= 1'b0;
                    if (byte_valid) begin
                        case (byte_idx_r)
                            2'd0: word_buf_r[7:0]   <= byte_data;
                            2'd1: word_buf_r[15:8]  <= byte_data;
                            2'd2: word_buf_r[23:16] <= byte_data;
                            default: begin
                                // Fourth byte completes the word and goes straight to the write port.
                                mem_wd     <= {byte_data, word_buf_r};
                                mem_addr   <= word_addr(word_cnt_r);
                                mem_we     <= 1'b1;
                                byte_ready <= 1'b0;
                                state_r    <= WRITE;
                            end
                        endcase
                        byte_idx_r <= byte_idx_r + 2'd1;
                    end else begin
                        byte_idx_r <= byte_idx_r;
                    end
                end
                WRITE: begin
                    mem_we     <= 1'b0;
                    word_cnt_r <= word_cnt_nxt_s;
                    byte_idx_r <= 2'd0;
                    if (word_cnt_nxt_s == count_r) begin
                        state_r  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        core_rst <= 1'b1;
                    end else begin
                        state_r    <= LOAD;
                        byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    byte_ready <= 1'b0;
                    mem_we     <= 1'b0;
                    core_rst   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (BASE_ADDR 0 and 0x100) share one
// directed byte stream; expected writes are queued per instance and checked by a monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        byte_ready0, mem_we0, core_rst0, busy0, done0;
    logic [31:0] mem_addr0, mem_wd0;
    logic        byte_ready1, mem_we1, core_rst1, busy1, done1;
    logic [31:0] mem_addr1, mem_wd1;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0] q0[$];
    logic [63:0] q1[$];

    logic [31:0] words[3];

    always #5 clk = ~clk;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .CNT_W(10)) dut0 (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wd(mem_wd0),
        .core_rst(core_rst0), .busy(busy0), .done(done0)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100), .CNT_W(10)) dut1 (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wd(mem_wd1),
        .core_rst(core_rst1), .busy(busy1), .done(done1)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Monitor: every write strobe pops the matching expectation for its instance.
    always @(negedge clk) begin
        logic [63:0] e;
        if (mem_we0 === 1'b1) begin
            if (q0.size() == 0) check1("spurious_write0", mem_we0, 1'b0);
            else begin
                e = q0.pop_front();
                check32("addr0", mem_addr0, e[63:32]);
                check32("wd0", mem_wd0, e[31:0]);
                check1("ready_in_write0", byte_ready0, 1'b0);
            end
        end
        if (mem_we1 === 1'b1) begin
            if (q1.size() == 0) check1("spurious_write1", mem_we1, 1'b0);
            else begin
                e = q1.pop_front();
                check32("addr1", mem_addr1, e[63:32]);
                check32("wd1", mem_wd1, e[31:0]);
                check1("ready_in_write1", byte_ready1, 1'b0);
            end
        end
    end

    task automatic push_exp(input int idx, input logic [31:0] w);
        logic [31:0] off;
        off = 32'(idx) * 32'd4;
        q0.push_back({off, w});
        q1.push_back({32'h0000_0100 + off, w});
    endtask

    task automatic pulse_start(input logic [9:0] n);
        start = 1'b1;
        word_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic got;
        got = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        for (int i = 0; i < 40 && !got; i++) begin
            if (byte_ready0) begin
                @(posedge clk);
                got = 1'b1;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check1("byte_accept", got, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], int'($urandom_range(0, gapmax)));
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!done0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check1("done", done0, 1'b1);
        check1("core_rst_done", core_rst0, 1'b1);
        check1("busy_off", busy0, 1'b0);
        check32("q0_drained", 32'(q0.size()), 32'd0);
        check32("q1_drained", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        words[0] = 32'h1122_3344;
        words[1] = 32'hDEAD_BEEF;
        words[2] = 32'h0BAD_F00D;
        rst = 1'b0; start = 1'b0; word_count = 10'd0; byte_valid = 1'b0; byte_data = 8'd0;
        repeat (3) @(negedge clk);
        check1("rst_byte_ready", byte_ready0, 1'b0);
        check1("rst_mem_we", mem_we0, 1'b0);
        check32("rst_mem_addr", mem_addr0, 32'd0);
        check32("rst_mem_addr1", mem_addr1, 32'd0);
        check32("rst_mem_wd", mem_wd0, 32'd0);
        check1("rst_core_rst", core_rst0, 1'b0);
        check1("rst_busy", busy0, 1'b0);
        check1("rst_done", done0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Single word, back-to-back bytes: write in cycle 5, done the cycle after.
        push_exp(0, 32'hE3A0_0013);
        pulse_start(10'd1);
        check1("load_ready", byte_ready0, 1'b1);
        check1("load_busy", busy0, 1'b1);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA0, 0);
        send_byte(8'hE3, 0);
        check1("we_cycle5", mem_we0, 1'b1);
        @(negedge clk);
        check1("done_cycle6", done0, 1'b1);
        check1("core_rst_cycle6", core_rst0, 1'b1);

        // Restart from DONE: three words, no gaps.
        pulse_start(10'd3);
        check1("restart_core_rst", core_rst0, 1'b0);
        check1("restart_busy", busy0, 1'b1);
        for (int i = 0; i < 3; i++) push_exp(i, words[i]);
        for (int i = 0; i < 3; i++) send_word(words[i], 0);
        wait_done();

        // Same three words with random gaps and ignored start pulses in WRITE and LOAD.
        pulse_start(10'd3);
        for (int i = 0; i < 3; i++) push_exp(i, words[i]);
        send_word(words[0], 7);
        pulse_start(10'd1);
        send_byte(words[1][7:0], int'($urandom_range(0, 7)));
        send_byte(words[1][15:8], int'($urandom_range(0, 7)));
        pulse_start(10'd1);
        check1("start_in_load_busy", busy0, 1'b1);
        send_byte(words[1][23:16], int'($urandom_range(0, 7)));
        send_byte(words[1][31:24], int'($urandom_range(0, 7)));
        send_word(words[2], 7);
        wait_done();

        // Reset in the middle of word 2.
        pulse_start(10'd3);
        push_exp(0, words[0]);
        send_word(words[0], 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check1("midrst_ready", byte_ready0, 1'b0);
        check1("midrst_busy", busy0, 1'b0);
        check1("midrst_done", done0, 1'b0);
        check32("midrst_addr", mem_addr0, 32'd0);
        check32("midrst_wd", mem_wd0, 32'd0);
        byte_valid = 1'b1;
        byte_data = 8'hFF;
        repeat (8) @(negedge clk);
        byte_valid = 1'b0;
        check1("idle_no_ready", byte_ready0, 1'b0);

        // Zero-word load goes straight to DONE with no write.
        pulse_start(10'd0);
        check1("zero_done", done0, 1'b1);
        check1("zero_busy", busy0, 1'b0);
        check1("zero_core_rst", core_rst0, 1'b1);
        check1("zero_no_we", mem_we0, 1'b0);
        repeat (3) @(negedge clk);

        // Fresh load after reset starts at BASE_ADDR with lane 0.
        pulse_start(10'd2);
        push_exp(0, 32'hCAFE_0102);
        push_exp(1, 32'h8070_6050);
        send_word(32'hCAFE_0102, 3);
        send_word(32'h8070_6050, 3);
        wait_done();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
